// File: rtl/arb4_rr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb4_rr_ctrl: 4-requester round-robin burst arbiter with data select.    |
// | Optional ARB4_TIMEOUT_EN adds a HoldMax-cycle forced grant release.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module arb4_rr_ctrl #(
  parameter int DataWidth = 32,
  parameter int HoldMax   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             req_i,
  input  logic [3:0]             last_i,
  input  logic [4*DataWidth-1:0] data_i,
  input  logic                   ready_i,
  output logic [3:0]             gnt_o,
  output logic [1:0]             sel_o,
  output logic                   valid_o,
  output logic [DataWidth-1:0]   data_o,
  output logic                   busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] pick;
  logic       found;
  logic       req_sel;
  logic       last_sel;
  logic       xfer;
  logic       release_grant;
  logic       timeout;

  if (HoldMax < 2 || HoldMax > 255) begin : g_bad_holdmax
    $error("arb4_rr_ctrl: HoldMax must be in 2..255");
  end

`ifdef ARB4_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout = (state_q == ST_BUSY) && (cnt_q == 8'(HoldMax - 1));
`else
  assign timeout = 1'b0;
`endif

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[ptr_q + 2'(i)]) begin
        pick  = ptr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign req_sel       = req_i[sel_q];
  assign last_sel      = last_i[sel_q];
  assign busy_o        = (state_q == ST_BUSY);
  assign valid_o       = busy_o && req_sel && !timeout;
  assign xfer          = valid_o && ready_i;
  assign release_grant = (xfer && last_sel) || !req_sel || timeout;
  assign gnt_o         = gnt_q;
  assign sel_o         = sel_q;

  always_comb begin
    data_o = data_i[DataWidth-1:0];
    case (sel_q)
      2'd0: data_o = data_i[0*DataWidth +: DataWidth];
      2'd1: data_o = data_i[1*DataWidth +: DataWidth];
      2'd2: data_o = data_i[2*DataWidth +: DataWidth];
      2'd3: data_o = data_i[3*DataWidth +: DataWidth];
      default: data_o = data_i[DataWidth-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB4_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
`ifdef ARB4_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      ST_BUSY: begin
        if (release_grant) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end else begin
`ifdef ARB4_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB4_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb4_rr_ctrl.sv
`default_nettype none
// Testbench for arb4_rr_ctrl: directed scenarios plus randomized traffic
// against a rule-level round-robin model.
module tb_arb4_rr_ctrl;

  localparam int DW = 16;
`ifdef ARB4_TIMEOUT_EN
  localparam int HOLD  = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int HOLD  = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      last;
  logic [4*DW-1:0] data;
  logic            ready;
  logic [3:0]      gnt_o;
  logic [1:0]      sel_o;
  logic            valid_o;
  logic            busy_o;
  logic [DW-1:0]   data_o;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, where the search starts, hold age.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;

  arb4_rr_ctrl #(.DataWidth(DW), .HoldMax(HOLD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .last_i (last),
    .data_i (data),
    .ready_i(ready),
    .gnt_o  (gnt_o),
    .sel_o  (sel_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  // Expected {gnt, sel, busy, valid, data} for the current inputs.
  function automatic logic [DW+7:0] model_out();
    logic [3:0]    g;
    logic          v;
    logic [DW-1:0] d;
    g = m_busy ? 4'(1 << m_sel) : 4'b0000;
    v = m_busy && req[m_sel] && !(TO_EN && m_cnt == HOLD - 1);
    d = data[m_sel*DW +: DW];
    return {g, 2'(m_sel), m_busy, v, d};
  endfunction

  task automatic model_step();
    bit to_hit;
    bit v;
    bit found;
    if (!m_busy) begin
      if (req != 4'b0000) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      to_hit = TO_EN && (m_cnt == HOLD - 1);
      v      = req[m_sel] && !to_hit;
      if ((v && ready && last[m_sel]) || !req[m_sel] || to_hit) begin
        m_busy = 1'b0;
        m_ptr  = (m_sel + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock; structural invariants are checked on every cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!$onehot0(gnt_o) || ((gnt_o != 4'b0000) !== busy_o) || (valid_o && !busy_o)) begin
      errors++;
      $display("FAIL invariant: gnt=%b busy=%b valid=%b (need one-hot-or-zero gnt, gnt!=0 iff busy, no valid when idle)",
               gnt_o, busy_o, valid_o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst   = 1'b1;
    req   = 4'b1111;
    last  = 4'b1111;
    ready = 1'b1;
    data  = {$urandom(), $urandom()};
    model_reset();
    #1;
    got = {gnt_o, sel_o, busy_o, valid_o};
    checks++;
    if (got !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_async: gnt/sel/busy/valid=%b need 00000000", got);
    end
    tick();
    #1;
    got = {gnt_o, sel_o, busy_o, valid_o};
    checks++;
    if (got !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_held: gnt/sel/busy/valid=%b need 00000000", got);
    end
    checks++;
    if (data_o !== data[DW-1:0]) begin
      errors++;
      $display("FAIL reset_data: data_o=%h need %h", data_o, data[DW-1:0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0]    tbl [9];
    logic [DW+7:0] exp;
    tbl = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
            4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req   = 4'b1111;
    last  = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = {$urandom(), $urandom()};
      #1;
      exp = model_out();
      checks++;
      if ({gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
        errors++;
        $display("FAIL rotation_model cyc%0d: got %h need %h", i, {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
      end
      if (i > 0) begin
        checks++;
        if (gnt_o !== tbl[i-1]) begin
          errors++;
          $display("FAIL rotation_seq cyc%0d: gnt=%b need %b", i, gnt_o, tbl[i-1]);
        end
      end
      model_step();
      tick();
    end
  endtask

  task automatic test_burst();
    logic [DW+7:0] exp;
    int beats = 0;
    int bcyc  = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      data = {$urandom(), $urandom()};
      if (m_busy) begin
        ready = (bcyc % 2 == 0);
        bcyc++;
      end else begin
        ready = 1'b1;
      end
      last = (beats == 2) ? 4'b0100 : 4'b0000;
      req  = (beats < 3) ? 4'b0100 : 4'b0000;
      #1;
      exp = model_out();
      checks++;
      if ({gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
        errors++;
        $display("FAIL burst_model cyc%0d: got %h need %h", c, {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
      end
      if (valid_o && ready) begin
        beats++;
        checks++;
        if (data_o !== data[2*DW +: DW]) begin
          errors++;
          $display("FAIL burst_data beat%0d: data_o=%h need %h", beats, data_o, data[2*DW +: DW]);
        end
      end
      model_step();
      tick();
    end
    checks++;
    if (beats !== 3 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL burst_count: beats=%0d busy=%b need 3 beats and idle", beats, busy_o);
    end
  endtask

  task automatic test_abandon();
    logic [3:0]    tbl [7];
    logic [DW+7:0] exp;
    tbl = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000};
    do_reset();
    last  = 4'b0000;
    ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      data = {$urandom(), $urandom()};
      req  = (c == 0) ? 4'b0010 : (c < 3) ? 4'b1010 : 4'b1000;
      #1;
      exp = model_out();
      checks++;
      if ({gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
        errors++;
        $display("FAIL abandon_model cyc%0d: got %h need %h", c, {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
      end
      checks++;
      if (gnt_o !== tbl[c]) begin
        errors++;
        $display("FAIL abandon_seq cyc%0d: gnt=%b need %b", c, gnt_o, tbl[c]);
      end
      model_step();
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [DW+7:0] exp;
    logic [7:0]    got;
    do_reset();
    req   = 4'b0100;
    last  = 4'b0000;
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data = {$urandom(), $urandom()};
      #1;
      exp = model_out();
      checks++;
      if ({gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
        errors++;
        $display("FAIL arst_pre cyc%0d: got %h need %h", c, {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
      end
      model_step();
      tick();
    end
    #3;
    rst = 1'b1;
    #1;
    got = {gnt_o, sel_o, busy_o, valid_o};
    checks++;
    if (got !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL arst_immediate: gnt/sel/busy/valid=%b need 00000000", got);
    end
    model_reset();
    @(negedge clk);
    req = 4'b1100;
    rst = 1'b0;
    #1;
    model_step();
    tick();
    #1;
    exp = model_out();
    checks++;
    if (gnt_o !== 4'b0100 || {gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
      errors++;
      $display("FAIL arst_regrant: gnt=%b need 0100 (full got %h need %h)", gnt_o,
               {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
    end
  endtask

`ifdef ARB4_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0]    gtbl [7];
    logic          vtbl [7];
    logic [DW+7:0] exp;
    int            xf = 0;
    gtbl = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    vtbl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    req   = 4'b0011;
    last  = 4'b0000;
    ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      data = {$urandom(), $urandom()};
      #1;
      exp = model_out();
      if (valid_o && ready) xf++;
      checks++;
      if (gnt_o !== gtbl[c] || valid_o !== vtbl[c] || {gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
        errors++;
        $display("FAIL timeout cyc%0d: gnt=%b valid=%b need gnt=%b valid=%b", c, gnt_o, valid_o, gtbl[c], vtbl[c]);
      end
      model_step();
      tick();
    end
    checks++;
    if (xf !== 0) begin
      errors++;
      $display("FAIL timeout_xfers: transfers=%0d need 0", xf);
    end
  endtask
`else
  task automatic test_hold();
    logic [DW+7:0] exp;
    do_reset();
    req   = 4'b0011;
    last  = 4'b0000;
    ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      data = {$urandom(), $urandom()};
      #1;
      exp = model_out();
      checks++;
      if ({gnt_o, sel_o, busy_o, valid_o, data_o} !== exp || (c > 0 && gnt_o !== 4'b0001)) begin
        errors++;
        $display("FAIL hold cyc%0d: got %h need %h (gnt must stay 0001)", c,
                 {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
      end
      model_step();
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [DW+7:0] exp;
    do_reset();
    req = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (req[b]) begin
          if ($urandom_range(0, 9) == 0) req[b] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[b] = 1'b1;
        end
        last[b] = ($urandom_range(0, 3) == 0);
      end
      ready = ($urandom_range(0, 9) < 7);
      data  = {$urandom(), $urandom()};
      #1;
      exp = model_out();
      checks++;
      if ({gnt_o, sel_o, busy_o, valid_o, data_o} !== exp) begin
        errors++;
        $display("FAIL random cyc%0d: req=%b last=%b rdy=%b got %h need %h", c, req, last, ready,
                 {gnt_o, sel_o, busy_o, valid_o, data_o}, exp);
      end
      model_step();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_burst();
    test_abandon();
    test_async_reset();
`ifdef ARB4_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
